dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning data memory size in 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning extra access cycles between accept and response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  load/store request present.
REQ-006 SHALL have port req_ready  output  1  controller can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store (driven from decoder dm_en), 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RV32I load/store width/sign code.
REQ-009 SHALL have port req_addr  input  32  byte address (ALU result).
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-013 SHALL have port rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  request illegal; no memory update performed.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-016 SHALL accept a request when req_valid && req_ready, latching we, funct3, addr, wdata; inputs ignored otherwise.
REQ-017 SHALL transition IDLE->RESP on accept when WAIT_CYCLES=0, else IDLE->WAIT loading a down-counter with WAIT_CYCLES-1.
REQ-018 SHALL leave WAIT for RESP when the counter equals 0, decrementing it otherwise; rsp_valid rises exactly 1+WAIT_CYCLES cycles after the accept edge.
REQ-019 SHALL perform the memory read/write on the edge entering RESP (commit point); no write before it.
REQ-020 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready=1, then go to IDLE on that edge; back-to-back throughput is one request per 2+WAIT_CYCLES cycles.
REQ-021 SHALL index memory with addr[log2(DEPTH_WORDS)+1:2]; upper bits ignored (address wraps).
REQ-022 SHALL decode loads: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend; byte lane by addr[1:0], halfword by addr[1].
REQ-023 SHALL decode stores: 000 SB, 001 SH, 010 SW using byte enables from addr[1:0]; unaddressed bytes unchanged.
REQ-024 SHALL flag any other funct3 (including 011, 110, 111, and 100/101 for stores) with rsp_err=1, rsp_rdata=0, no write.

Reset
REQ-025 SHALL on rst force state IDLE, counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-026 SHALL abandon any request in WAIT on rst without writing memory; rst has priority over all events in the same cycle.
REQ-027 SHALL NOT reset memory contents.

Configuration
REQ-028 SHALL, with DMEM_MISALIGN_CHECK_EN defined, respond rsp_err=1, rsp_rdata=0, no write for halfword with addr[0]=1 or word with addr[1:0]!=0.
REQ-029 SHALL, without DMEM_MISALIGN_CHECK_EN, ignore addr[0] for halfwords and addr[1:0] for words (align down), rsp_err only per REQ-024.

Verification
REQ-030 SHALL cover: WAIT_CYCLES=1, SW 0xDEADBEEF @0x10 then LW @0x10 -> rsp_valid 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-031 SHALL cover: SB 0x80 @0x13 over word 0x00000000, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80000000.
REQ-032 SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready 0, new req_valid ignored until release.
REQ-033 SHALL cover: LW @0x12 -> with DMEM_MISALIGN_CHECK_EN err=1 rdata 0; without, returns word @0x10.
REQ-034 SHALL cover: funct3=011 store -> err=1, memory unchanged on subsequent LW; rst asserted during WAIT of SW -> next LW shows old value, outputs at reset values.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: RV32I load/store controller with a wait-state FSM in front of a byte-lane data RAM.
// Optional DMEM_MISALIGN_CHECK_EN: misaligned halfword/word accesses respond with rsp_err instead of aligning down.
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_reg;
    logic [3:0]      cnt_reg;
    logic            we_reg;
    logic [2:0]      funct3_reg;
    logic [31:0]     addr_reg;
    logic [31:0]     wdata_reg;
    logic            req_ready_reg;
    logic            rsp_valid_reg;
    logic            rsp_err_reg;

    logic            accept;
    logic            commit;
    logic            op_we;
    logic [2:0]      op_funct3;
    logic [31:0]     op_addr;
    logic [31:0]     op_wdata;
    logic            illegal;
    logic            misaligned;
    logic            op_err;
    logic            wr_en;
    logic [3:0]      be;
    logic [31:0]     wlane;
    logic [AW-1:0]   idx;
    logic [3:0][7:0] rd_word;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     load_data;
    logic            addr_unused;

    assign accept = req_valid && req_ready_reg;

    // With zero wait states the commit edge is also the accept edge, so the
    // operation must come straight from the request inputs in IDLE.
    assign op_we     = (state_reg == IDLE) ? req_we     : we_reg;
    assign op_funct3 = (state_reg == IDLE) ? req_funct3 : funct3_reg;
    assign op_addr   = (state_reg == IDLE) ? req_addr   : addr_reg;
    assign op_wdata  = (state_reg == IDLE) ? req_wdata  : wdata_reg;

    assign commit = !rst && (((state_reg == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                             ((state_reg == WAIT) && (cnt_reg == 4'd0)));

    assign idx         = op_addr[AW+1:2];
    assign addr_unused = &{1'b0, op_addr[31:AW+2]};

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (op_we) begin
            illegal = !(op_funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            illegal = !(op_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
`ifdef DMEM_MISALIGN_CHECK_EN
        if (op_funct3[1:0] == 2'b01) begin
            misaligned = op_addr[0];
        end else if (op_funct3[1:0] == 2'b10) begin
            misaligned = (op_addr[1:0] != 2'b00);
        end
`endif
    end

    assign op_err = illegal || misaligned;
    assign wr_en  = commit && op_we && !op_err;

    // Store data is replicated across lanes so each lane just picks its own byte.
    always_comb begin
        be    = 4'b1111;
        wlane = op_wdata;
        case (op_funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << op_addr[1:0];
                wlane = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                be    = op_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{op_wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = op_wdata;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (wr_en && be[gi]) begin
                    mem[idx] <= wlane[gi*8 +: 8];
                end
                if (commit) begin
                    rd_byte_reg <= mem[idx];
                end
            end

            assign rd_word[gi] = rd_byte_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            we_reg        <= 1'b0;
            funct3_reg    <= 3'd0;
            addr_reg      <= 32'd0;
            wdata_reg     <= 32'd0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        we_reg        <= req_we;
                        funct3_reg    <= req_funct3;
                        addr_reg      <= req_addr;
                        wdata_reg     <= req_wdata;
                        req_ready_reg <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_reg     <= RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= op_err;
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= op_err;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                        rsp_err_reg   <= 1'b0;
                        req_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    cnt_reg       <= 4'd0;
                    req_ready_reg <= 1'b1;
                    rsp_valid_reg <= 1'b0;
                    rsp_err_reg   <= 1'b0;
                end
            endcase
        end
    end

    // Load extraction works on the word captured at commit and the latched request.
    always_comb begin
        byte_sel  = rd_word[addr_reg[1:0]];
        half_sel  = addr_reg[1] ? {rd_word[3], rd_word[2]} : {rd_word[1], rd_word[0]};
        load_data = 32'd0;
        case (funct3_reg)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = 32'd0;
        endcase
        if (!rsp_valid_reg || we_reg || rsp_err_reg) begin
            load_data = 32'd0;
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = load_data;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed load/store vectors; the driver queues expected responses, a negedge monitor checks them.
module tb_dmem_ctrl;
    localparam int W = 1;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   prev_valid = 0;
    bit   have_cur = 0;

    dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: first valid cycle pops the scoreboard; later stalled cycles must hold the same values.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 0;
            have_cur   = 0;
        end else begin
            if (rsp_valid) begin
                if (!prev_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        have_cur = 0;
                        $display("FAIL unexpected_rsp: got rdata %h err %0d expected none", rsp_rdata, rsp_err);
                    end else begin
                        cur = exp_q.pop_front();
                        have_cur = 1;
                        check({cur.name, "_latency"}, 32'(cyc - cur.acc), 32'(1 + W));
                        check({cur.name, "_rdata"}, rsp_rdata, cur.rdata);
                        check({cur.name, "_err"}, {31'd0, rsp_err}, {31'd0, cur.err});
                        $display("rsp %-12s rdata=%h err=%0d", cur.name, rsp_rdata, rsp_err);
                    end
                end else if (have_cur) begin
                    check({cur.name, "_hold_rdata"}, rsp_rdata, cur.rdata);
                    check({cur.name, "_hold_err"}, {31'd0, rsp_err}, {31'd0, cur.err});
                end
                check("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
            end
            prev_valid = rsp_valid;
        end
    end

    task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] er, input logic ee);
        int   n;
        exp_t e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_accept_timeout: got req_ready 0 expected 1", name);
            req_valid = 1'b0;
            return;
        end
        e.name  = name;
        e.rdata = er;
        e.err   = ee;
        e.acc   = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic txn(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee);
        do_req(name, we, f3, a, wd, er, ee);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        rst = 1'b0;

        txn("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        txn("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        txn("sw_10_zero", 1'b1, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0);
        txn("sb_13", 1'b1, 3'b000, 32'h13, 32'h00000080, 32'h0, 1'b0);
        txn("lb_13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
        txn("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0);
        txn("lw_10_sb", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80000000, 1'b0);

        txn("sw_14", 1'b1, 3'b010, 32'h14, 32'h12345678, 32'h0, 1'b0);
        txn("sh_16", 1'b1, 3'b001, 32'h16, 32'h0000ABCD, 32'h0, 1'b0);
        txn("lh_16", 1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFFABCD, 1'b0);
        txn("lhu_16", 1'b0, 3'b101, 32'h16, 32'h0, 32'h0000ABCD, 1'b0);
        txn("lh_14", 1'b0, 3'b001, 32'h14, 32'h0, 32'h00005678, 1'b0);
        txn("lb_15", 1'b0, 3'b000, 32'h15, 32'h0, 32'h00000056, 1'b0);
        txn("lw_wrap", 1'b0, 3'b010, 32'h1010, 32'h0, 32'h80000000, 1'b0);

`ifdef DMEM_MISALIGN_CHECK_EN
        txn("lw_12_mis", 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
        txn("lh_17_mis", 1'b0, 3'b001, 32'h17, 32'h0, 32'h0, 1'b1);
`else
        txn("lw_12_mis", 1'b0, 3'b010, 32'h12, 32'h0, 32'h80000000, 1'b0);
        txn("lh_17_mis", 1'b0, 3'b001, 32'h17, 32'h0, 32'hFFFFABCD, 1'b0);
`endif

        txn("st_f3_011", 1'b1, 3'b011, 32'h10, 32'h12345678, 32'h0, 1'b1);
        txn("st_f3_100", 1'b1, 3'b100, 32'h10, 32'h12345678, 32'h0, 1'b1);
        txn("ld_f3_110", 1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1);
        txn("lw_after_bad", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80000000, 1'b0);

        // Stalled response: a store presented during the stall must not be taken.
        txn("sw_20", 1'b1, 3'b010, 32'h20, 32'h11111111, 32'h0, 1'b0);
        rsp_ready = 1'b0;
        do_req("lw_20_stall", 1'b0, 3'b010, 32'h20, 32'h0, 32'h11111111, 1'b0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'h22222222;
        repeat (5) @(negedge clk);
        check("stall_valid_held", {31'd0, rsp_valid}, 32'd1);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        txn("lw_20_after", 1'b0, 3'b010, 32'h20, 32'h0, 32'h11111111, 1'b0);

        // Reset while the store sits in WAIT: nothing may be written.
        do_req("sw_10_rst", 1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0);
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("wrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("wrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("wrst_rsp_rdata", rsp_rdata, 32'd0);
        check("wrst_rsp_err", {31'd0, rsp_err}, 32'd0);
        rst = 1'b0;
        txn("lw_10_post_rst", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80000000, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
